// File: rtl/lif_array.sv
// lif_array: N leaky integrate-and-fire neurons sharing one evaluation datapath.
// A step request captures the inputs, then one channel is evaluated and written
// per clock cycle. done pulses for one cycle after the last channel is written.
// Optional build macro LIF_ARRAY_ADAPT_THRESH_EN adds a per-channel adaptive
// threshold offset that grows on each spike and decays on every other evaluation.
module lif_array #(
    parameter int W         = 8,
    parameter int N         = 4,
    parameter int REFRAC    = 2,
    parameter int ADAPT_INC = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             step,
    input  logic [N*W-1:0]   current,
    input  logic [1:0]       beta_sel,
    input  logic [W-1:0]     thresh_base,
    output logic             busy,
    output logic             done,
    output logic [N-1:0]     spike,
    output logic [N*W-1:0]   state
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int RW = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;
    localparam logic [CW-1:0] LAST_CH  = CW'(N - 1);
    localparam logic [RW-1:0] REFRAC_R = RW'(REFRAC);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} fsm_e;

    // Saturating W-bit add: the carry out of a W+1 bit sum clamps to all ones.
    function automatic logic [W-1:0] sat_add(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum[W]) begin
            sat_add = {W{1'b1}};
        end else begin
            sat_add = sum[W-1:0];
        end
    endfunction

    // Membrane leak. Option 3 keeps 7/8 of U via three shifted copies; the sum
    // never exceeds U, so truncating back to W bits loses nothing.
    function automatic logic [W-1:0] leak(input logic [W-1:0] u, input logic [1:0] sel);
        logic [W+1:0] sum;
        sum = {2'b00, u >> 3'd1} + {2'b00, u >> 3'd2} + {2'b00, u >> 3'd3};
        case (sel)
            2'd0:    leak = u >> 3'd1;
            2'd1:    leak = u >> 3'd2;
            2'd2:    leak = u >> 3'd3;
            2'd3:    leak = sum[W-1:0];
            default: leak = u >> 3'd1;
        endcase
    endfunction

    fsm_e            fsm_q;
    logic [CW-1:0]   cnt_q;
    logic            busy_q;
    logic            done_q;
    logic [N-1:0]    spike_q;
    logic [W-1:0]    u_q   [N];
    logic [RW-1:0]   rc_q  [N];
    logic [W-1:0]    cur_q [N];
    logic [1:0]      beta_q;
    logic [W-1:0]    thr_q;

    logic [W-1:0]    v_s;
    logic [W-1:0]    theta_s;
    logic [W-1:0]    u_d;
    logic [RW-1:0]   rc_d;
    logic            spk_d;

`ifdef LIF_ARRAY_ADAPT_THRESH_EN
    localparam logic [W-1:0] ADAPT_INC_W = W'(ADAPT_INC);
    logic [W-1:0]    b_q [N];
    logic [W-1:0]    b_d;

    // Adaptive threshold for the channel under evaluation and its next offset.
    always_comb begin
        theta_s = sat_add(thr_q, b_q[cnt_q]);
        if (spk_d) begin
            b_d = sat_add(b_q[cnt_q], ADAPT_INC_W);
        end else begin
            b_d = b_q[cnt_q] - (b_q[cnt_q] >> 3'd2);
        end
    end
`else
    // Fixed threshold: the captured base value is used directly.
    always_comb begin
        theta_s = thr_q;
    end
`endif

    // Evaluate the channel selected by the counter: leak, integrate, fire or rest.
    always_comb begin
        v_s = sat_add(leak(u_q[cnt_q], beta_q), cur_q[cnt_q]);
        if (rc_q[cnt_q] != {RW{1'b0}}) begin
            spk_d = 1'b0;
            u_d   = {W{1'b0}};
            rc_d  = rc_q[cnt_q] - RW'(1'b1);
        end else if (v_s >= theta_s) begin
            spk_d = 1'b1;
            u_d   = {W{1'b0}};
            rc_d  = REFRAC_R;
        end else begin
            spk_d = 1'b0;
            u_d   = v_s;
            rc_d  = {RW{1'b0}};
        end
    end

    // Control FSM, input capture and per-channel state write-back.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm_q   <= IDLE;
            cnt_q   <= {CW{1'b0}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            spike_q <= {N{1'b0}};
            beta_q  <= 2'b00;
            thr_q   <= {W{1'b0}};
            for (int k = 0; k < N; k++) begin
                u_q[k]   <= {W{1'b0}};
                rc_q[k]  <= {RW{1'b0}};
                cur_q[k] <= {W{1'b0}};
`ifdef LIF_ARRAY_ADAPT_THRESH_EN
                b_q[k]   <= {W{1'b0}};
`endif
            end
        end else begin
            done_q <= 1'b0;
            case (fsm_q)
                IDLE: begin
                    if (step) begin
                        fsm_q   <= RUN;
                        busy_q  <= 1'b1;
                        cnt_q   <= {CW{1'b0}};
                        spike_q <= {N{1'b0}};
                        beta_q  <= beta_sel;
                        thr_q   <= thresh_base;
                        for (int k = 0; k < N; k++) begin
                            cur_q[k] <= current[k*W +: W];
                        end
                    end
                end
                RUN: begin
                    u_q[cnt_q]     <= u_d;
                    rc_q[cnt_q]    <= rc_d;
                    spike_q[cnt_q] <= spk_d;
`ifdef LIF_ARRAY_ADAPT_THRESH_EN
                    b_q[cnt_q]     <= b_d;
`endif
                    if (cnt_q == LAST_CH) begin
                        fsm_q  <= IDLE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        cnt_q  <= {CW{1'b0}};
                    end else begin
                        cnt_q  <= cnt_q + CW'(1'b1);
                    end
                end
                default: begin
                    fsm_q  <= IDLE;
                    busy_q <= 1'b0;
                    cnt_q  <= {CW{1'b0}};
                end
            endcase
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign spike = spike_q;

    for (genvar g = 0; g < N; g++) begin : g_state
        assign state[g*W +: W] = u_q[g];
    end

endmodule
